// File: rtl/reorder_buffer.sv
// AXI-style read reorder buffer: AR forwarded unchanged, R data parked per ID and
// replayed upstream in AR accept order. Optional macro: REORDER_BUFFER_DUP_ID_CHECK_EN.
module reorder_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  input  logic [3:0]            s_arid_i,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [3:0]            s_rid_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  output logic [3:0]            m_arid_o,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  input  logic [3:0]            m_rid_i
);
  localparam int DEPTH = 16;

  logic [DEPTH-1:0][3:0]            ord_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
  logic [DEPTH-1:0]                 vld_q;
  logic [3:0]                       wr_ptr_q, rd_ptr_q, head;
  logic [4:0]                       cnt_q, cnt_d;
  logic                             full, empty, ar_stall, push, pop;

  assign full  = (cnt_q == 5'd16);
  assign empty = (cnt_q == 5'd0);

`ifdef REORDER_BUFFER_DUP_ID_CHECK_EN
  // One bit per ID currently sitting in the order FIFO.
  logic [DEPTH-1:0] out_q;
  assign ar_stall = full | out_q[s_arid_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      if (pop)  out_q[head]     <= 1'b0;
      if (push) out_q[s_arid_i] <= 1'b1;
    end
  end
`else
  assign ar_stall = full;
`endif

  assign m_arid_o    = s_arid_i;
  assign m_arvalid_o = s_arvalid_i & ~ar_stall;
  assign s_arready_o = m_arready_i & ~ar_stall;
  assign m_rready_o  = 1'b1;

  assign head       = ord_q[rd_ptr_q];
  assign s_rvalid_o = ~empty & vld_q[head];
  assign s_rid_o    = head;
  assign s_rdata_o  = data_q[head];

  assign push  = s_arvalid_i & s_arready_o;
  assign pop   = s_rvalid_o & s_rready_i;
  assign cnt_d = cnt_q + 5'(push) - 5'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ord_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        ord_q[wr_ptr_q] <= s_arid_i;
        wr_ptr_q        <= wr_ptr_q + 4'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 4'd1;
      cnt_q <= cnt_d;
    end
  end

  // Capture is unconditional: every outstanding ID owns its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pop && head == 4'(i)) vld_q[i] <= 1'b0;
        if (m_rvalid_i && m_rid_i == 4'(i)) begin
          vld_q[i]  <= 1'b1;
          data_q[i] <= m_rdata_i;
        end
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: in-order replay of out-of-order returns,
// full stall, backpressure and mid-flight reset.
module tb_reorder_buffer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_arvalid_i, s_arready_o, s_rvalid_o, s_rready_i;
  logic [3:0] s_arid_i, s_rid_o, m_arid_o, m_rid_i;
  logic [7:0] s_rdata_o, m_rdata_i;
  logic       m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o;

  int total = 0;
  int bad   = 0;

  reorder_buffer #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o), .s_arid_i(s_arid_i),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i), .s_rdata_o(s_rdata_o), .s_rid_o(s_rid_o),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_arid_o(m_arid_o),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .m_rdata_i(m_rdata_i), .m_rid_i(m_rid_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ar(input logic [3:0] id);
    s_arvalid_i = 1'b1; s_arid_i = id; m_arready_i = 1'b1;
    #1 check("ar_ready", s_arready_o, 1);
    tick();
    s_arvalid_i = 1'b0;
  endtask

  task automatic rret(input logic [3:0] id, input logic [7:0] d);
    m_rvalid_i = 1'b1; m_rid_i = id; m_rdata_i = d;
    tick();
    m_rvalid_i = 1'b0;
  endtask

  task automatic beat(input logic [3:0] id, input logic [7:0] d);
    s_rready_i = 1'b1;
    #1;
    check("beat_valid", s_rvalid_o, 1);
    check("beat_id", s_rid_o, id);
    check("beat_data", s_rdata_o, d);
    tick();
    s_rready_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; s_arvalid_i = 1'b0; s_arid_i = 4'd5; m_arready_i = 1'b1;
    s_rready_i = 1'b0; m_rvalid_i = 1'b0; m_rid_i = '0; m_rdata_i = '0;
    #2;
    check("rst_rvalid", s_rvalid_o, 0);
    check("rst_rid", s_rid_o, 0);
    check("rst_rdata", s_rdata_o, 0);
    check("rst_rready", m_rready_o, 1);
    check("rst_arready", s_arready_o, 1);
    check("rst_arvalid", m_arvalid_o, 0);
    check("rst_arid", m_arid_o, 5);
    m_arready_i = 1'b0; s_arvalid_i = 1'b1;
    #1;
    check("rst_arready_lo", s_arready_o, 0);
    check("rst_arvalid_hi", m_arvalid_o, 1);
    s_arvalid_i = 1'b0; m_arready_i = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // single read
    ar(4'd3);
    m_rvalid_i = 1'b1; m_rid_i = 4'd3; m_rdata_i = 8'hA5;
    #1 check("single_pre", s_rvalid_o, 0);
    tick();
    m_rvalid_i = 1'b0;
    beat(4'd3, 8'hA5);
    #1 check("single_done", s_rvalid_o, 0);

    // reverse return
    ar(4'd1); ar(4'd2); ar(4'd3);
    rret(4'd3, 8'h33);
    check("rev_wait3", s_rvalid_o, 0);
    rret(4'd2, 8'h22);
    check("rev_wait2", s_rvalid_o, 0);
    rret(4'd1, 8'h11);
    beat(4'd1, 8'h11); beat(4'd2, 8'h22); beat(4'd3, 8'h33);
    #1 check("rev_done", s_rvalid_o, 0);

    // full, in-order returns
    for (int i = 0; i < 16; i++) ar(4'(i));
    s_arvalid_i = 1'b1; s_arid_i = 4'd5;
    #1;
    check("full_arready", s_arready_o, 0);
    check("full_arvalid", m_arvalid_o, 0);
    s_arvalid_i = 1'b0;
    for (int i = 0; i < 16; i++) rret(4'(i), 8'(i * 8'h11));
    check("full_still", s_arready_o, 0);
    s_rready_i = 1'b1;
    #1 check("full_pop_cycle", s_arready_o, 0);
    beat(4'd0, 8'h00);
    check("full_resume", s_arready_o, 1);
    for (int i = 1; i < 16; i++) beat(4'(i), 8'(i * 8'h11));
    #1 check("full_done", s_rvalid_o, 0);

    // full, reverse returns
    for (int i = 0; i < 16; i++) ar(4'(i));
    for (int i = 15; i >= 1; i--) rret(4'(i), 8'(8'h40 + i));
    s_rready_i = 1'b1;
    #1 check("back_wait", s_rvalid_o, 0);
    s_rready_i = 1'b0;
    rret(4'd0, 8'h40);
    for (int i = 0; i < 16; i++) beat(4'(i), 8'(8'h40 + i));
    #1 check("back_done", s_rvalid_o, 0);

    // backpressure
    ar(4'd7);
    rret(4'd7, 8'h5C);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", s_rvalid_o, 1);
      check("bp_id", s_rid_o, 7);
      check("bp_data", s_rdata_o, 8'h5C);
      tick();
    end
    beat(4'd7, 8'h5C);
    #1 check("bp_done", s_rvalid_o, 0);

    // reset mid-flight
    ar(4'd4); ar(4'd5); ar(4'd6); ar(4'd7);
    rret(4'd4, 8'h44);
    check("mid_head", s_rvalid_o, 1);
    rst_n = 1'b0;
    #1 check("mid_rst", s_rvalid_o, 0);
    tick();
    rst_n = 1'b1;
    rret(4'd5, 8'h55);
    rret(4'd6, 8'h66);
    check("mid_late", s_rvalid_o, 0);
    ar(4'd0);
    rret(4'd0, 8'h0A);
    beat(4'd0, 8'h0A);
    #1 check("mid_done", s_rvalid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

AXI-style read reorder buffer placed between an upstream read requester (slave side) and a downstream memory/interconnect (master side) that may return read data out of order. Read addresses are forwarded downstream unchanged. Returned data is captured per ID and replayed upstream strictly in the order the AR requests were accepted. Supports up to 16 outstanding reads, one per 4-bit ID.

## Interface
- DATA_WIDTH, 8, width of read data.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- s_arvalid_i  in  1  upstream AR valid.
- s_arready_o  out  1  upstream AR ready.
- s_arid_i  in  4  upstream AR ID.
- s_rvalid_o  out  1  upstream R valid.
- s_rready_i  in  1  upstream R ready.
- s_rdata_o  out  DATA_WIDTH  upstream R data.
- s_rid_o  out  4  upstream R ID.
- m_arvalid_o  out  1  downstream AR valid.
- m_arready_i  in  1  downstream AR ready.
- m_arid_o  out  4  downstream AR ID.
- m_rvalid_i  in  1  downstream R valid.
- m_rready_o  out  1  downstream R ready.
- m_rdata_i  in  DATA_WIDTH  downstream R data.
- m_rid_i  in  4  downstream R ID.

## Operation
- State: 16-entry order FIFO of IDs (accept order), count 0..16; per-ID data array (16 x DATA_WIDTH) with per-ID valid bit.
- AR path combinational: m_arid_o = s_arid_i; m_arvalid_o = s_arvalid_i & ~full; s_arready_o = m_arready_i & ~full. full = count==16.
- AR handshake (s_arvalid_i & s_arready_o): push s_arid_i into order FIFO tail.
- m_rready_o = 1 constantly; storage slot for every outstanding ID always exists.
- R capture (m_rvalid_i): data[m_rid_i] <= m_rdata_i, valid[m_rid_i] <= 1.
- R output: head = order FIFO head ID. s_rvalid_o = ~empty & valid[head]; s_rid_o = head; s_rdata_o = data[head].
- R handshake (s_rvalid_o & s_rready_i): pop FIFO, clear valid[head].
- Same-cycle push and pop: count unchanged, both pointers advance. Same-cycle capture into ID X and pop of ID X cannot occur (X not yet valid); capture into other IDs unaffected.
- Pointers 4-bit, wrap 15->0 naturally.
- Responses with an ID not outstanding are a protocol violation; data is stored but never emitted until that ID is requested (undefined otherwise).
- s_rdata_o/s_rid_o hold while s_rvalid_o & ~s_rready_i (AXI stability).

## Timing
- Reset: FIFO empty, pointers/count 0, all valid bits 0, data array 0. Outputs during reset: s_rvalid_o=0, s_rid_o=0, s_rdata_o=0, m_rready_o=1, s_arready_o=m_arready_i, m_arvalid_o=s_arvalid_i, m_arid_o=s_arid_i.
- AR: zero-cycle pass-through.
- R: data captured at edge N appears on s_r* from cycle N+1 if its ID is FIFO head; otherwise when it becomes head.
- Back-to-back: one upstream R beat per cycle when data is present and s_rready_i=1.
- Full (16 outstanding): s_arready_o=0, m_arvalid_o=0 until a pop; pop and new accept may occur in same cycle only if full deasserted (full is registered count, so accept resumes the cycle after the pop).
- Reset asserted mid-operation: all outstanding state discarded immediately.

## Configuration
- REORDER_BUFFER_DUP_ID_CHECK_EN: when defined, an AR whose ID is already outstanding (present in order FIFO) is stalled: s_arready_o=0, m_arvalid_o=0 until that ID is popped. When undefined, unique outstanding IDs are an upstream contract and no check logic is built.

## Test plan
- Single read: AR ID 3 accepted, m_r ID 3 data 0xA5 -> next cycle s_rvalid_o=1, s_rid_o=3, s_rdata_o=0xA5; one beat.
- Reverse return: ARs IDs 1,2,3; downstream returns 3(0x33),2(0x22),1(0x11) -> upstream emits 1/0x11, 2/0x22, 3/0x33 in order, first beat one cycle after ID 1 captured.
- Full straight: 16 ARs IDs 0..15 -> 17th AR stalled (s_arready_o=0); returns in order 0..15 with data=ID*0x11 -> upstream identical order, afterwards AR accepted again.
- Full back: 16 ARs IDs 0..15, downstream returns 15..0 -> no upstream beat until ID 0 arrives, then 16 consecutive beats 0..15 with s_rready_i=1.
- Backpressure: s_rready_i=0 for 5 cycles with head valid -> s_rvalid_o stays 1, s_rid_o/s_rdata_o stable, no pop.
- Reset mid-flight: 4 outstanding, rst_n low 1 cycle -> s_rvalid_o=0, late m_r responses ignored for output, fresh AR ID 0 round-trips normally.
